// File: rtl/ram_loader_pkg.sv
// ---------------------------------------------------------------------------
// ram_loader_pkg
// Shared definitions for the RAM loader: parameter defaults, the per-lane
// packing mode encodings and the lane state enumeration.
// ---------------------------------------------------------------------------
package ram_loader_pkg;

   localparam int CHANNELS_DEF  = 3;
   localparam int ELEM_W_DEF    = 16;
   localparam int BURST_LEN_DEF = 8;
   localparam int IN_W_DEF      = 32;
   localparam int ADDR_W_DEF    = 10;

   // Packing mode of a lane: one or two elements taken from each input word
   localparam logic MODE_SINGLE = 1'b0;
   localparam logic MODE_DUAL   = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,   // no elements buffered
      ST_FILL = 2'd1,   // partial burst buffered
      ST_DONE = 2'd2    // address limit written, lane stalled until clear/reset
   } lane_state_t;

endpackage

// File: rtl/ram_loader_lane.sv
// ---------------------------------------------------------------------------
// ram_loader_lane
// One loader lane: packs incoming elements into a BURST_LEN-element RAM word
// and emits a one-cycle write pulse per full (or flushed) burst, advancing
// the address until the programmed limit has been written.
//
// Ports
//   clk, rst_n   clock, synchronous active-low reset
//   clear        synchronous soft clear (same effect as reset)
//   i_mode       0: one element per word, 1: two elements (low half first)
//   i_valid      input strobe
//   i_data       input word
//   i_flush      write the partial burst, unfilled elements zeroed
//   i_limit      last legal RAM address
//   o_ready      lane accepts input
//   o_we         one-cycle RAM write pulse
//   o_addr       RAM write address
//   o_data       packed burst, element 0 in the least significant slot
//   o_full       limit address has been written
//   o_ovf        sticky: input offered while o_ready was low
// ---------------------------------------------------------------------------
module ram_loader_lane
   import ram_loader_pkg::*;
#(
   parameter int ELEM_W    = ELEM_W_DEF,
   parameter int BURST_LEN = BURST_LEN_DEF,
   parameter int IN_W      = IN_W_DEF,
   parameter int ADDR_W    = ADDR_W_DEF
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        clear,
   input  logic                        i_mode,
   input  logic                        i_valid,
   input  logic [IN_W-1:0]             i_data,
   input  logic                        i_flush,
   input  logic [ADDR_W-1:0]           i_limit,
   output logic                        o_ready,
   output logic                        o_we,
   output logic [ADDR_W-1:0]           o_addr,
   output logic [BURST_LEN*ELEM_W-1:0] o_data,
   output logic                        o_full,
   output logic                        o_ovf
);

   localparam int CNT_W  = $clog2(BURST_LEN + 1);
   localparam int DATA_W = BURST_LEN * ELEM_W;

   lane_state_t         r_state;
   lane_state_t         w_state_nxt;
   logic [CNT_W-1:0]    r_cnt;
   logic [CNT_W-1:0]    w_cnt_sum;
   logic                r_mode;
   logic                w_mode_eff;
   logic [DATA_W-1:0]   r_buf;
   logic [DATA_W-1:0]   w_buf_nxt;
   logic [DATA_W-1:0]   r_wdata;
   logic [ADDR_W-1:0]   r_addr;
   logic [ADDR_W-1:0]   w_addr_now;
   logic                r_we;
   logic                r_ovf;
   logic                w_ready;
   logic                w_accept;
   logic                w_write;

   assign w_ready  = (r_state != ST_DONE);
   assign w_accept = i_valid & w_ready;

   // The mode only takes effect at the start of a burst; mid-burst changes
   // on i_mode are ignored.
   assign w_mode_eff = (r_cnt == '0) ? i_mode : r_mode;

   // r_addr advances on the cycle after a write, so a burst completing while
   // that write is still on the port must already use the next address.
   assign w_addr_now = r_we ? (r_addr + ADDR_W'(1)) : r_addr;

   // Insert the accepted element(s) at the current fill position.
   always_comb begin
      w_buf_nxt = r_buf;
      w_cnt_sum = r_cnt;
      if (w_accept) begin
         for (int i = 0; i < BURST_LEN; i++) begin
            if (CNT_W'(i) == r_cnt)
               w_buf_nxt[i*ELEM_W +: ELEM_W] = i_data[ELEM_W-1:0];
            if ((w_mode_eff == MODE_DUAL) && (CNT_W'(i) == r_cnt + CNT_W'(1)))
               w_buf_nxt[i*ELEM_W +: ELEM_W] = i_data[2*ELEM_W-1:ELEM_W];
         end
         w_cnt_sum = r_cnt + ((w_mode_eff == MODE_DUAL) ? CNT_W'(2) : CNT_W'(1));
      end
   end

   // A flush counts the element(s) accepted in the same cycle, so a flush
   // together with an accept still yields exactly one write.
   assign w_write = w_ready &
                    ((w_cnt_sum == CNT_W'(BURST_LEN)) | (i_flush & (w_cnt_sum != '0)));

   always_ff @(posedge clk) begin
      if (!rst_n || clear) r_state <= ST_IDLE;
      else                 r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE, ST_FILL: begin
            if (w_write)
               w_state_nxt = (w_addr_now == i_limit) ? ST_DONE : ST_IDLE;
            else if (w_accept)
               w_state_nxt = ST_FILL;
         end
         ST_DONE: w_state_nxt = ST_DONE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         r_cnt   <= '0;
         r_mode  <= MODE_SINGLE;
         r_buf   <= '0;
         r_wdata <= '0;
         r_addr  <= '0;
         r_we    <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_we <= w_write;
         if (i_valid && !w_ready)
            r_ovf <= 1'b1;
         if (w_accept && (r_cnt == '0))
            r_mode <= i_mode;
         if (w_write) begin
            // Clearing the buffer here is what zero-fills a later flush.
            r_wdata <= w_buf_nxt;
            r_buf   <= '0;
            r_cnt   <= '0;
            r_addr  <= w_addr_now;
         end else begin
            r_buf <= w_buf_nxt;
            r_cnt <= w_cnt_sum;
            // After the write to the limit the address stays put.
            if (r_we && (r_state != ST_DONE))
               r_addr <= r_addr + ADDR_W'(1);
         end
      end
   end

   assign o_ready = w_ready;
   assign o_we    = r_we;
   assign o_addr  = r_addr;
   assign o_data  = r_wdata;
   assign o_full  = (r_state == ST_DONE);
   assign o_ovf   = r_ovf;

endmodule

// File: rtl/ram_loader.sv
// ---------------------------------------------------------------------------
// ram_loader
// CHANNELS independent loader lanes that pack narrow input elements into
// BURST_LEN-element RAM words. Lanes share only clk, rst_n and clear; every
// vector port carries one slice per lane, lane k at slice k.
//
// Ports
//   clk, rst_n   clock, synchronous active-low reset
//   clear        synchronous soft clear of all lanes
//   mode         per lane: 0 one element per word, 1 two elements per word
//   in_valid     per-lane input strobe
//   in_data      per-lane input words (IN_W each)
//   flush        per-lane request to write a partial burst
//   limit        per-lane last legal RAM address (ADDR_W each)
//   in_ready     per-lane input acceptance
//   ram_we       per-lane one-cycle write pulse
//   ram_addr     per-lane write address (ADDR_W each)
//   ram_data     per-lane packed burst (BURST_LEN*ELEM_W each)
//   full         per-lane: limit address written
//   ovf          per-lane sticky overflow flag
// BURST_LEN must be even and >= 2; IN_W must be >= 2*ELEM_W.
// ---------------------------------------------------------------------------
module ram_loader
   import ram_loader_pkg::*;
#(
   parameter int CHANNELS  = CHANNELS_DEF,
   parameter int ELEM_W    = ELEM_W_DEF,
   parameter int BURST_LEN = BURST_LEN_DEF,
   parameter int IN_W      = IN_W_DEF,
   parameter int ADDR_W    = ADDR_W_DEF
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 clear,
   input  logic [CHANNELS-1:0]                  mode,
   input  logic [CHANNELS-1:0]                  in_valid,
   input  logic [CHANNELS*IN_W-1:0]             in_data,
   input  logic [CHANNELS-1:0]                  flush,
   input  logic [CHANNELS*ADDR_W-1:0]           limit,
   output logic [CHANNELS-1:0]                  in_ready,
   output logic [CHANNELS-1:0]                  ram_we,
   output logic [CHANNELS*ADDR_W-1:0]           ram_addr,
   output logic [CHANNELS*BURST_LEN*ELEM_W-1:0] ram_data,
   output logic [CHANNELS-1:0]                  full,
   output logic [CHANNELS-1:0]                  ovf
);

   localparam int DATA_W = BURST_LEN * ELEM_W;

   for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
      ram_loader_lane #(
         .ELEM_W    (ELEM_W),
         .BURST_LEN (BURST_LEN),
         .IN_W      (IN_W),
         .ADDR_W    (ADDR_W)
      ) u_lane (
         .clk     (clk),
         .rst_n   (rst_n),
         .clear   (clear),
         .i_mode  (mode[g]),
         .i_valid (in_valid[g]),
         .i_data  (in_data[g*IN_W +: IN_W]),
         .i_flush (flush[g]),
         .i_limit (limit[g*ADDR_W +: ADDR_W]),
         .o_ready (in_ready[g]),
         .o_we    (ram_we[g]),
         .o_addr  (ram_addr[g*ADDR_W +: ADDR_W]),
         .o_data  (ram_data[g*DATA_W +: DATA_W]),
         .o_full  (full[g]),
         .o_ovf   (ovf[g])
      );
   end

endmodule

// File: tb/tb_ram_loader.sv
// ---------------------------------------------------------------------------
// tb_ram_loader
// Self-checking bench for ram_loader: directed vector table, hand-written
// limit/clear/reset sequences and randomized traffic on all lanes, all
// compared against a burst-level reference model.
// ---------------------------------------------------------------------------
module tb_ram_loader;

   localparam int CH = 3;
   localparam int EW = 16;
   localparam int BL = 8;
   localparam int IW = 32;
   localparam int AW = 10;
   localparam int DW = BL * EW;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              clear;
   logic [CH-1:0]     mode;
   logic [CH-1:0]     in_valid;
   logic [CH*IW-1:0]  in_data;
   logic [CH-1:0]     flush;
   logic [CH*AW-1:0]  limit;
   logic [CH-1:0]     in_ready;
   logic [CH-1:0]     ram_we;
   logic [CH*AW-1:0]  ram_addr;
   logic [CH*DW-1:0]  ram_data;
   logic [CH-1:0]     full;
   logic [CH-1:0]     ovf;

   always #5 clk = ~clk;

   ram_loader #(
      .CHANNELS (CH), .ELEM_W (EW), .BURST_LEN (BL), .IN_W (IW), .ADDR_W (AW)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (clear),
      .mode     (mode),
      .in_valid (in_valid),
      .in_data  (in_data),
      .flush    (flush),
      .limit    (limit),
      .in_ready (in_ready),
      .ram_we   (ram_we),
      .ram_addr (ram_addr),
      .ram_data (ram_data),
      .full     (full),
      .ovf      (ovf)
   );

   int n_chk = 0;
   int n_err = 0;

   // Reference model: per lane a list of buffered elements, the next write
   // address, the done/overflow flags and the last word written.
   logic [EW-1:0] m_el   [CH][BL];
   int            m_n    [CH];
   logic          m_mode [CH];
   int            m_addr [CH];
   bit            m_done [CH];
   bit            m_ovf  [CH];
   logic [DW-1:0] m_last [CH];
   bit            e_we   [CH];
   int            e_waddr[CH];
   int            we_seen[CH];

   task automatic chk(input string nm, input int ln, input logic [DW-1:0] act,
                      input logic [DW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s lane%0d: got %h expected %h", nm, ln, act, exp);
      end
   endtask

   task automatic model_reset(input int k);
      m_n[k]    = 0;
      m_mode[k] = 1'b0;
      m_addr[k] = 0;
      m_done[k] = 1'b0;
      m_ovf[k]  = 1'b0;
      m_last[k] = '0;
   endtask

   // Predict this cycle from the applied inputs, clock once, then compare.
   task automatic cycle();
      logic [DW-1:0] d;
      for (int k = 0; k < CH; k++) begin
         e_we[k] = 1'b0;
         if (!rst_n || clear) begin
            model_reset(k);
         end else begin
            if (in_valid[k]) begin
               if (m_done[k]) begin
                  m_ovf[k] = 1'b1;
               end else begin
                  if (m_n[k] == 0) m_mode[k] = mode[k];
                  m_el[k][m_n[k]] = in_data[k*IW +: EW];
                  m_n[k]++;
                  if (m_mode[k]) begin
                     m_el[k][m_n[k]] = in_data[k*IW+EW +: EW];
                     m_n[k]++;
                  end
               end
            end
            if (m_n[k] == BL || (flush[k] && m_n[k] > 0)) begin
               d = '0;
               for (int i = 0; i < m_n[k]; i++) d[i*EW +: EW] = m_el[k][i];
               e_we[k]    = 1'b1;
               e_waddr[k] = m_addr[k];
               m_last[k]  = d;
               m_n[k]     = 0;
               if (m_addr[k] == int'(limit[k*AW +: AW])) m_done[k] = 1'b1;
               else                                      m_addr[k]++;
            end
         end
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < CH; k++) begin
         if (ram_we[k]) we_seen[k]++;
         chk("ram_we",   k, DW'(ram_we[k]), DW'(e_we[k]));
         chk("ram_addr", k, DW'(ram_addr[k*AW +: AW]),
             e_we[k] ? DW'(e_waddr[k]) : DW'(m_addr[k]));
         chk("ram_data", k, ram_data[k*DW +: DW], m_last[k]);
         chk("in_ready", k, DW'(in_ready[k]), DW'(!m_done[k]));
         chk("full",     k, DW'(full[k]), DW'(m_done[k]));
         chk("ovf",      k, DW'(ovf[k]), DW'(m_ovf[k]));
      end
   endtask

   task automatic idle_inputs();
      in_valid = '0;
      flush    = '0;
      mode     = '0;
      in_data  = '0;
   endtask

   typedef struct packed {
      logic [1:0]    lane;
      logic          md;
      logic          vld;
      logic [IW-1:0] din;
      logic          fl;
      logic          exp_we;
      logic [AW-1:0] exp_addr;
      logic          chk_d;
      logic [DW-1:0] exp_d;
   } vec_t;

   function automatic vec_t mkv(input int ln, input logic md, input logic vld,
                                input logic [IW-1:0] din, input logic fl,
                                input logic ewe, input int eaddr,
                                input logic cd, input logic [DW-1:0] ed);
      vec_t v;
      v.lane = 2'(ln); v.md = md; v.vld = vld; v.din = din; v.fl = fl;
      v.exp_we = ewe; v.exp_addr = AW'(eaddr); v.chk_d = cd; v.exp_d = ed;
      return v;
   endfunction

   vec_t tbl[$];

   initial begin
      logic [DW-1:0] seq8;
      int ln;
      int base;

      seq8 = 128'h0008_0007_0006_0005_0004_0003_0002_0001;

      // Lane 0, mode 0: eight words, garbage in the upper half.
      for (int w = 1; w <= 8; w++)
         tbl.push_back(mkv(0, 1'b0, 1'b1, 32'hDEAD_0000 | IW'(w), 1'b0,
                           w == 8, 0, w == 8, seq8));
      tbl.push_back(mkv(0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1, 1'b1, seq8));
      // Flush with nothing buffered does nothing.
      tbl.push_back(mkv(0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1, 1'b1, seq8));
      // Lane 1, mode 1: four dual words, then a fifth starts burst 1.
      for (int w = 1; w <= 4; w++)
         tbl.push_back(mkv(1, 1'b1, 1'b1, {16'(2*w), 16'(2*w-1)}, 1'b0,
                           w == 4, 0, w == 4, seq8));
      tbl.push_back(mkv(1, 1'b1, 1'b1, 32'h000A_0009, 1'b0, 1'b0, 1, 1'b1, seq8));
      tbl.push_back(mkv(1, 1'b0, 1'b0, '0, 1'b1, 1'b1, 1, 1'b1, 128'h000A_0009));
      // Lane 2, mode 0: three words and a flush, then flush with an accept.
      tbl.push_back(mkv(2, 1'b0, 1'b1, 32'hBEEF_0011, 1'b0, 1'b0, 0, 1'b0, '0));
      tbl.push_back(mkv(2, 1'b1, 1'b1, 32'hBEEF_0022, 1'b0, 1'b0, 0, 1'b0, '0));
      tbl.push_back(mkv(2, 1'b1, 1'b1, 32'hBEEF_0033, 1'b0, 1'b0, 0, 1'b0, '0));
      tbl.push_back(mkv(2, 1'b0, 1'b0, '0, 1'b1, 1'b1, 0, 1'b1, 128'h0033_0022_0011));
      tbl.push_back(mkv(2, 1'b0, 1'b1, 32'h0000_0044, 1'b1, 1'b1, 1, 1'b1, 128'h0044));
      tbl.push_back(mkv(2, 1'b0, 1'b0, '0, 1'b0, 1'b0, 2, 1'b1, 128'h0044));

      for (int k = 0; k < CH; k++) begin
         model_reset(k);
         we_seen[k] = 0;
      end
      rst_n = 1'b0;
      clear = 1'b0;
      limit = {CH{AW'(1023)}};
      idle_inputs();
      cycle();
      cycle();
      rst_n = 1'b1;
      cycle();
      chk("rst_ready", 0, DW'(in_ready), DW'(3'b111));
      chk("rst_addr",  0, DW'(ram_addr), '0);

      // ---------------- directed vector table
      foreach (tbl[r]) begin
         idle_inputs();
         ln = int'(tbl[r].lane);
         in_valid[ln] = tbl[r].vld;
         mode[ln]     = tbl[r].md;
         flush[ln]    = tbl[r].fl;
         in_data[ln*IW +: IW] = tbl[r].din;
         cycle();
         chk("tbl_we",   ln, DW'(ram_we[ln]), DW'(tbl[r].exp_we));
         chk("tbl_addr", ln, DW'(ram_addr[ln*AW +: AW]), DW'(tbl[r].exp_addr));
         if (tbl[r].chk_d) chk("tbl_data", ln, ram_data[ln*DW +: DW], tbl[r].exp_d);
      end
      idle_inputs();

      // ---------------- limit = 1: two bursts, then the lane stalls
      limit[0 +: AW] = AW'(1);
      clear = 1'b1;
      cycle();
      clear = 1'b0;
      chk("clr_ready", 0, DW'(in_ready[0]), DW'(1'b1));
      base = we_seen[0];
      for (int w = 1; w <= 24; w++) begin
         in_valid[0] = 1'b1;
         in_data[0 +: IW] = IW'(w);
         cycle();
      end
      idle_inputs();
      cycle();
      chk("lim_writes", 0, DW'(we_seen[0] - base), DW'(2));
      chk("lim_full",   0, DW'(full[0]), DW'(1'b1));
      chk("lim_ready",  0, DW'(in_ready[0]), DW'(1'b0));
      chk("lim_ovf",    0, DW'(ovf[0]), DW'(1'b1));
      chk("lim_addr",   0, DW'(ram_addr[0 +: AW]), DW'(1));
      flush[0] = 1'b1;
      cycle();
      flush[0] = 1'b0;

      // ---------------- clear mid-burst, dominating valid and flush
      limit[0 +: AW] = AW'(1023);
      clear = 1'b1;
      cycle();
      clear = 1'b0;
      chk("clr_full", 0, DW'(full[0]), DW'(1'b0));
      chk("clr_ovf",  0, DW'(ovf[0]), DW'(1'b0));
      for (int w = 1; w <= 5; w++) begin
         in_valid[0] = 1'b1;
         in_data[0 +: IW] = IW'(w);
         cycle();
      end
      base = we_seen[0];
      flush[0] = 1'b1;
      clear = 1'b1;
      cycle();
      clear = 1'b0;
      idle_inputs();
      cycle();
      cycle();
      chk("clr_nowrite", 0, DW'(we_seen[0] - base), '0);
      for (int w = 1; w <= 8; w++) begin
         in_valid[0] = 1'b1;
         in_data[0 +: IW] = IW'(w);
         cycle();
      end
      idle_inputs();
      chk("clr_wr_addr", 0, DW'(ram_addr[0 +: AW]), '0);
      chk("clr_wr_data", 0, ram_data[0 +: DW], seq8);

      // ---------------- reset mid-burst
      for (int w = 1; w <= 3; w++) begin
         in_valid[0] = 1'b1;
         in_data[0 +: IW] = IW'(w);
         cycle();
      end
      base = we_seen[0];
      rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
      chk("rst_data", 0, ram_data[0 +: DW], '0);
      for (int w = 1; w <= 8; w++) begin
         in_valid[0] = 1'b1;
         in_data[0 +: IW] = IW'(w + 16);
         cycle();
      end
      idle_inputs();
      chk("rst_writes",  0, DW'(we_seen[0] - base), DW'(1));
      chk("rst_wr_addr", 0, DW'(ram_addr[0 +: AW]), '0);
      chk("rst_wr_we",   0, DW'(ram_we[0]), DW'(1'b1));

      // ---------------- randomized traffic on all lanes at once
      for (int k = 0; k < CH; k++) limit[k*AW +: AW] = AW'($urandom_range(7, 0));
      clear = 1'b1;
      cycle();
      clear = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         for (int k = 0; k < CH; k++) begin
            in_valid[k] = ($urandom_range(9, 0) < 7);
            mode[k]     = $urandom_range(1, 0) == 1;
            flush[k]    = ($urandom_range(24, 0) == 0);
            in_data[k*IW +: IW] = $urandom;
         end
         clear = ($urandom_range(199, 0) == 0);
         rst_n = ($urandom_range(499, 0) != 0);
         if (clear || !rst_n)
            for (int k = 0; k < CH; k++) limit[k*AW +: AW] = AW'($urandom_range(7, 0));
         cycle();
      end
      clear = 1'b0;
      rst_n = 1'b1;
      idle_inputs();
      cycle();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/ram_loader.md
RAM_LOADER -- requirements
Module: ram_loader

Interface
REQ-001 Parameter CHANNELS, default 3: number of independent loader lanes.
REQ-002 Parameter ELEM_W, default 16: element width in bits.
REQ-003 Parameter BURST_LEN, default 8: elements packed per RAM word; must be even and at least 2.
REQ-004 Parameter IN_W, default 32: input word width; must be at least 2*ELEM_W.
REQ-005 Parameter ADDR_W, default 10: RAM address width.
REQ-006 Port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 Port rst_n, input, 1 bit: one clock; reset is synchronous and active-low.
REQ-008 Port clear, input, 1 bit: synchronous soft clear of all lanes.
REQ-009 Port mode, input, CHANNELS bits: per lane, 0 = one element per input word (IN bits [ELEM_W-1:0]); 1 = two elements per word, low half first, then high half.
REQ-010 Port in_valid, input, CHANNELS bits: per-lane input strobe.
REQ-011 Port in_data, input, CHANNELS*IN_W bits: per-lane input words, lane k at slice k.
REQ-012 Port flush, input, CHANNELS bits: per-lane request to write a partial burst.
REQ-013 Port limit, input, CHANNELS*ADDR_W bits: per-lane last legal RAM address.
REQ-014 Port in_ready, output, CHANNELS bits: lane accepts input.
REQ-015 Port ram_we, output, CHANNELS bits: one-cycle RAM write pulse.
REQ-016 Port ram_addr, output, CHANNELS*ADDR_W bits: write address.
REQ-017 Port ram_data, output, CHANNELS*BURST_LEN*ELEM_W bits: packed burst.
REQ-018 Port full, output, CHANNELS bits: lane has written address limit.
REQ-019 Port ovf, output, CHANNELS bits: sticky flag, input was offered while in_ready was low.

Function
REQ-020 Lanes are fully independent and share only clk, rst_n and clear.
REQ-021 Lane FSM states and transitions:
- IDLE (cnt = 0) to FILL on accept.
- FILL to IDLE on burst write.
- IDLE or FILL to DONE after the write to address limit.
- DONE to IDLE only on clear or reset.
REQ-022 in_ready is 1 in IDLE and FILL, and 0 in DONE; accept = in_valid AND in_ready.
REQ-023 Lane mode is latched on an accept when cnt = 0; changes to mode mid-burst are ignored.
REQ-024 Packing order: element i of a burst occupies ram_data lane bits [(i+1)*ELEM_W-1 : i*ELEM_W]; element 0 is the first received.
REQ-025 Each accept adds 1 element (mode 0) or 2 elements (mode 1) to cnt.
REQ-026 Burst write: when cnt reaches BURST_LEN, the next cycle carries ram_we=1 with the current ram_addr and the packed ram_data.
- Latency from the completing accept to ram_we is exactly 1 cycle.
- cnt is 0 and accepts continue without a bubble.
REQ-027 Address handling:
- ram_addr increments by 1 after each write.
- A write at ram_addr = limit enters DONE, holds ram_addr at limit and asserts full.
- Address wrap-around never occurs.
REQ-028 Flush with cnt > 0: zero the unfilled elements and write as in REQ-026, with ram_addr advancing.
REQ-029 Flush with cnt = 0 and no accept, or in DONE, is a no-op.
REQ-030 Flush coinciding with an accept: the accepted element(s) are included first, then the flush applies; exactly one write results.
REQ-031 in_valid while in_ready = 0 sets ovf; data is dropped and no other state changes.
REQ-032 ram_data holds its value between writes; ram_we is never high on two consecutive cycles unless bursts complete back-to-back.

Reset
REQ-033 rst_n = 0 or clear = 1 at a clock edge:
- cnt = 0, ram_addr = 0, packed data = 0.
- ram_we = 0, full = 0, ovf = 0, state IDLE, latched mode = 0.
- in_ready = 1 from the following cycle.
REQ-034 clear dominates in_valid and flush in the same cycle; a partial burst is discarded without a write.

Structure
REQ-035 Package ram_loader_pkg holds the parameter defaults, the MODE_SINGLE/MODE_DUAL encodings and the lane state enumeration.
REQ-036 One sub-module, ram_loader_lane, implements a single lane; ram_loader instantiates it CHANNELS times in a generate loop.

Verification
REQ-037 Mode 0, lane 0, 8 words 0x0001..0x0008 back-to-back: one ram_we 1 cycle after the 8th word, ram_addr 0, ram_data 0x0008_0007_..._0001.
REQ-038 Mode 1, lane 1, 4 words 0x0002_0001..0x0008_0007: one write at addr 0 with the same packing as REQ-037; a 5th word begins the burst for addr 1.
REQ-039 Mode 0, 3 words then flush: write with elements 3..7 = 0, next burst goes to addr 1.
REQ-040 limit = 1, 24 words in mode 0: writes at addr 0 and 1, then full = 1 and in_ready = 0; the third burst's words set ovf and produce no ram_we.
REQ-041 Apply clear after 5 words, or rst_n = 0 mid-burst: no write occurs, all outputs return to reset values, next burst writes addr 0.
REQ-042 All three lanes driven simultaneously with different modes: writes and addresses are per-lane correct with no cross-lane interference.
